// File: rtl/program_sequencer.sv
// Program sequencer: owns the PC and picks the next program-memory address.
// Optional jump trace buffer is enabled with `define PS_JUMP_TRACE_EN.
module program_sequencer #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_reset,
    input  logic                   hold,
    input  logic                   jmp,
    input  logic                   jmp_nz,
    input  logic                   dont_jmp,
    input  logic [3:0]             ir_nibble,
    output logic [PC_WIDTH-1:0]    pm_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   jump_taken,
    output logic [CNT_WIDTH-1:0]   jmp_count,
`ifdef PS_JUMP_TRACE_EN
    input  logic [1:0]             trace_idx,
    output logic [2*PC_WIDTH-1:0]  trace_data,
`endif
    output logic [7:0]             from_PS
);

    typedef enum logic [1:0] {
        SEL_RESTART,
        SEL_HOLD,
        SEL_JUMP,
        SEL_SEQ
    } addr_sel_e;

    addr_sel_e               sel;
    logic [PC_WIDTH-1:0]     pc_q, pc_d;
    logic [PC_WIDTH-1:0]     target;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    jump_req;

    assign target   = {ir_nibble, {(PC_WIDTH-4){1'b0}}};
    assign jump_req = jmp || (jmp_nz && !dont_jmp);

    // reset_n forces the restart path so pm_addr reads 0 during reset
    always_comb begin
        sel = SEL_SEQ;
        if (!reset_n || sync_reset) begin
            sel = SEL_RESTART;
        end else if (hold) begin
            sel = SEL_HOLD;
        end else if (jump_req) begin
            sel = SEL_JUMP;
        end
    end

    always_comb begin
        pm_addr    = pc_q + PC_WIDTH'(1);
        jump_taken = 1'b0;
        unique case (sel)
            SEL_RESTART: pm_addr = '0;
            SEL_HOLD:    pm_addr = pc_q;
            SEL_JUMP: begin
                pm_addr    = target;
                jump_taken = 1'b1;
            end
            SEL_SEQ:     pm_addr = pc_q + PC_WIDTH'(1);
            default:     pm_addr = '0;
        endcase
    end

    always_comb begin
        pc_d  = pm_addr;
        cnt_d = cnt_q;
        if (jump_taken && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc        = pc_q;
    assign jmp_count = cnt_q;

    generate
        if (PC_WIDTH >= 8) begin : g_dbg_wide
            assign from_PS = pc_q[7:0];
        end else begin : g_dbg_narrow
            assign from_PS = {{(8-PC_WIDTH){1'b0}}, pc_q};
        end
    endgenerate

`ifdef PS_JUMP_TRACE_EN
    logic [2*PC_WIDTH-1:0] trace_q [4];
    logic [2*PC_WIDTH-1:0] trace_d [4];
    logic [1:0]            wp_q, wp_d;
    logic [1:0]            rd_idx;

    always_comb begin
        trace_d = trace_q;
        wp_d    = wp_q;
        if (jump_taken) begin
            trace_d[wp_q] = {pc_q, target};
            wp_d          = wp_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                trace_q[i] <= '0;
            end
            wp_q <= '0;
        end else begin
            trace_q <= trace_d;
            wp_q    <= wp_d;
        end
    end

    // wp points at the next free slot, so the newest entry is wp-1
    assign rd_idx     = wp_q - 2'd1 - trace_idx;
    assign trace_data = trace_q[rd_idx];
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: table vectors, directed corners, random run.
// Two instances share inputs; the second has a 2-bit jump counter.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       sync_reset = 1'b0;
    logic       hold = 1'b0;
    logic       jmp = 1'b0;
    logic       jmp_nz = 1'b0;
    logic       dont_jmp = 1'b0;
    logic [3:0] ir_nibble = 4'h0;
    logic [7:0] pm_addr, pc, jmp_count, from_PS;
    logic       jump_taken;
    logic [7:0] pm_addr2, pc2, from_PS2;
    logic       jump_taken2;
    logic [1:0] jmp_count2;
`ifdef PS_JUMP_TRACE_EN
    logic [1:0]  trace_idx = 2'd0;
    logic [15:0] trace_data, trace_data2;
`endif

    int n_vec = 0;
    int n_err = 0;

    program_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
        .ir_nibble(ir_nibble), .pm_addr(pm_addr), .pc(pc),
        .jump_taken(jump_taken), .jmp_count(jmp_count),
`ifdef PS_JUMP_TRACE_EN
        .trace_idx(trace_idx), .trace_data(trace_data),
`endif
        .from_PS(from_PS)
    );

    program_sequencer #(.PC_WIDTH(8), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
        .hold(hold), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
        .ir_nibble(ir_nibble), .pm_addr(pm_addr2), .pc(pc2),
        .jump_taken(jump_taken2), .jmp_count(jmp_count2),
`ifdef PS_JUMP_TRACE_EN
        .trace_idx(trace_idx), .trace_data(trace_data2),
`endif
        .from_PS(from_PS2)
    );

    always #5 clk = ~clk;

    // reference model state
    int m_pc;
    int m_cnt;
    int m_cnt2;
    int m_trace[$];

    // actual values captured by the last step
    int a_pm, a_jt, a_pc, a_cnt, a_cnt2;

    typedef struct {
        bit sr, h, j, jnz, dj;
        int nib;
        int e_pm;
        int e_jt;
        int e_cnt;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pc   = 0;
        m_cnt  = 0;
        m_cnt2 = 0;
        m_trace = {0, 0, 0, 0};
    endtask

    // enter with reset_n high, leave at a negedge with reset released
    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        jmp = 1'b1;
        ir_nibble = 4'hC;
        sync_reset = 1'b0;
        hold = 1'b0;
        #1;
        model_clear();
        chk("async_pc", pc, 0);
        chk("async_cnt", jmp_count, 0);
        chk("rst_pm", pm_addr, 0);
        chk("rst_jt", jump_taken, 0);
        repeat (3) begin
            @(posedge clk);
            #1 chk("rst_pc_hold", pc, 0);
        end
        @(negedge clk);
        jmp = 1'b0;
        ir_nibble = 4'h0;
        reset_n = 1'b1;
    endtask

    task automatic step(input bit sr, input bit h, input bit j,
                        input bit jnz, input bit dj, input int nib);
        int exp_pm;
        int tgt;
        bit take;
        int idx;
        sync_reset = sr;
        hold = h;
        jmp = j;
        jmp_nz = jnz;
        dont_jmp = dj;
        ir_nibble = nib[3:0];
        idx = $urandom_range(0, 3);
`ifdef PS_JUMP_TRACE_EN
        trace_idx = idx[1:0];
`endif
        tgt = (nib % 16) * 16;
        take = 1'b0;
        if (sr) exp_pm = 0;
        else if (h) exp_pm = m_pc;
        else if (j || (jnz && !dj)) begin
            exp_pm = tgt;
            take = 1'b1;
        end else exp_pm = (m_pc + 1) % 256;
        #1;
        a_pm = int'(pm_addr);
        a_jt = int'(jump_taken);
        chk("pm_addr", pm_addr, exp_pm);
        chk("jump_taken", jump_taken, take);
        chk("from_PS", from_PS, m_pc);
`ifdef PS_JUMP_TRACE_EN
        chk("trace_data", trace_data, m_trace[3 - idx]);
`endif
        @(posedge clk);
        if (take) begin
            m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            m_trace.push_back(m_pc * 256 + tgt);
            void'(m_trace.pop_front());
        end
        m_pc = exp_pm;
        #1;
        a_pc = int'(pc);
        a_cnt = int'(jmp_count);
        a_cnt2 = int'(jmp_count2);
        chk("pc", pc, m_pc);
        chk("jmp_count", jmp_count, m_cnt);
        chk("jmp_count_sat", jmp_count2, m_cnt2);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    vec_t vt[$];
    int   sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        model_clear();
        vt = '{
            '{1, 0, 1, 0, 0, 10, 8'h00, 0, 0},
            '{0, 0, 0, 0, 0,  0, 8'h01, 0, 0},
            '{0, 0, 0, 0, 0,  0, 8'h02, 0, 0},
            '{0, 0, 0, 0, 0,  0, 8'h03, 0, 0},
            '{0, 0, 0, 0, 0,  0, 8'h04, 0, 0},
            '{0, 0, 0, 0, 0,  0, 8'h05, 0, 0},
            '{0, 0, 1, 0, 0, 10, 8'hA0, 1, 1},
            '{0, 0, 0, 1, 0,  2, 8'h20, 1, 2},
            '{0, 0, 0, 1, 1,  3, 8'h21, 0, 2},
            '{0, 0, 1, 0, 0,  2, 8'h20, 1, 3},
            '{0, 0, 0, 1, 0,  3, 8'h30, 1, 4},
            '{0, 0, 1, 0, 0,  4, 8'h40, 1, 5},
            '{0, 0, 0, 0, 0,  0, 8'h41, 0, 5},
            '{0, 0, 0, 0, 0,  0, 8'h42, 0, 5},
            '{0, 1, 1, 0, 0, 15, 8'h42, 0, 5},
            '{0, 0, 1, 1, 1, 15, 8'hF0, 1, 6},
            '{1, 1, 1, 0, 0,  7, 8'h00, 0, 6}
        };

        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("post_reset_pc", a_pc, i);
            chk("post_reset_cnt", a_cnt, 0);
        end

        foreach (vt[i]) begin
            step(vt[i].sr, vt[i].h, vt[i].j, vt[i].jnz, vt[i].dj, vt[i].nib);
            chk($sformatf("tbl%0d_pm", i), a_pm, vt[i].e_pm);
            chk($sformatf("tbl%0d_jt", i), a_jt, vt[i].e_jt);
            chk($sformatf("tbl%0d_pc", i), a_pc, vt[i].e_pm);
            chk($sformatf("tbl%0d_cnt", i), a_cnt, vt[i].e_cnt);
        end

        step(0, 0, 1, 0, 0, 15);
        idle(15);
        chk("wrap_pre", a_pc, 8'hFF);
        step(0, 0, 0, 0, 0, 0);
        chk("wrap_pc", a_pc, 0);
        chk("wrap_jt", a_jt, 0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 1);
            chk($sformatf("sat%0d", i), a_cnt2, sat_exp[i]);
            chk($sformatf("cnt%0d", i), a_cnt, i + 1);
        end

        do_reset();
        step(0, 0, 1, 0, 0, 7);
        chk("release_jump_pc", a_pc, 8'h70);

`ifdef PS_JUMP_TRACE_EN
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            step(1, 0, 0, 0, 0, 0);
            idle(k);
            step(0, 0, 1, 0, 0, k);
        end
        trace_idx = 2'd0;
        #1 chk("trace_newest", trace_data, 16'h0550);
        trace_idx = 2'd3;
        #1 chk("trace_oldest", trace_data, 16'h0220);
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trace_idx = i[1:0];
            #1 chk("trace_reset", trace_data, 0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
`endif

        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 15));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
